// File: rtl/cpu_pkg.sv
// Shared fetch-sequencing constants and types: reset/exception PCs, PC stride,
// privilege state and the next-PC source encoding.
package cpu_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
   localparam logic [31:0] PC_INC     = 32'd4;

   typedef enum logic {
      RUN    = 1'b0,
      KERNEL = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_JR   = 3'd2,
      SEL_JMP  = 3'd3,
      SEL_ERET = 3'd4,
      SEL_IRQ  = 3'd5,
      SEL_HOLD = 3'd6
   } pc_sel_e;

   // Modulo-2^32 sequential increment; wrap past 0xFFFF_FFFC is silent.
   function automatic logic [31:0] pc_inc(input logic [31:0] cur);
      return cur + PC_INC;
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational priority mux for the next fetch PC, flush strobes and irq acceptance.
// Zero latency; stall only holds the PC when no redirect is present.
module next_pc_sel
   import cpu_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] epc_i,
   input  logic        state_kernel_i,
   input  logic        irq_pend_i,
   input  logic        stall_i,
   input  logic        br_valid_i,
   input  logic        br_taken_i,
   input  logic [31:0] add_out_i,
   input  logic        jmp_valid_i,
   input  logic [31:0] jmp_target_i,
   input  logic        jr_valid_i,
   input  logic [31:0] jr_target_i,
   input  logic        eret_valid_i,
   input  logic        id_is_cf_i,
   output logic [31:0] next_pc_o,
   output logic        flush_if_o,
   output logic        flush_id_o,
   output logic        irq_accept_o,
   output logic        eret_accept_o
);

   pc_sel_e sel;
   logic    irq_ok;

   // Interrupts only enter on a clean boundary: nothing in flight that could redirect.
   assign irq_ok = !state_kernel_i && irq_pend_i && !stall_i && !br_valid_i
                   && !id_is_cf_i && !jmp_valid_i && !jr_valid_i;

   always_comb begin
      sel = SEL_SEQ;
      if (br_valid_i && br_taken_i) begin
         sel = SEL_BR;
      end else if (jr_valid_i) begin
         sel = SEL_JR;
      end else if (jmp_valid_i) begin
         sel = SEL_JMP;
      end else if (eret_valid_i && state_kernel_i) begin
         sel = SEL_ERET;
      end else if (irq_ok) begin
         sel = SEL_IRQ;
      end else if (stall_i) begin
         sel = SEL_HOLD;
      end
   end

   always_comb begin
      next_pc_o     = pc_inc(pc_i);
      flush_if_o    = 1'b0;
      flush_id_o    = 1'b0;
      irq_accept_o  = 1'b0;
      eret_accept_o = 1'b0;
      unique case (sel)
         SEL_BR: begin
            next_pc_o  = add_out_i;
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
         end
         SEL_JR: begin
            next_pc_o  = jr_target_i;
            flush_if_o = 1'b1;
         end
         SEL_JMP: begin
            next_pc_o  = jmp_target_i;
            flush_if_o = 1'b1;
         end
         SEL_ERET: begin
            next_pc_o     = epc_i;
            flush_if_o    = 1'b1;
            eret_accept_o = 1'b1;
         end
         SEL_IRQ: begin
            next_pc_o    = EXC_VECTOR;
            flush_if_o   = 1'b1;
            irq_accept_o = 1'b1;
         end
         SEL_HOLD: begin
            next_pc_o = pc_i;
         end
         default: begin
            next_pc_o = pc_inc(pc_i);
         end
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: registers pc/epc/irq_pend/state and drives the branch-target adder.
// New PC lands one edge after the decision; redirects override stall, flush strobes are same-cycle.
module pc_sequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic [31:0] imm_shift,
   output logic [31:0] add_pc,
   output logic [31:0] add_imm,
   input  logic [31:0] add_out,
   input  logic        jmp_valid,
   input  logic [31:0] jmp_target,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   input  logic        eret_valid,
   input  logic        id_is_cf,
   input  logic        irq,
   output logic [31:0] pc,
   output logic        flush_if,
   output logic        flush_id,
   output logic [31:0] epc,
   output logic        in_kernel
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic        irq_pend_q, irq_pend_d;
   logic        sel_flush_if, sel_flush_id;
   logic        irq_accept, eret_accept;

   assign add_pc  = br_pc;
   assign add_imm = imm_shift;

   next_pc_sel u_sel (
      .pc_i           (pc_q),
      .epc_i          (epc_q),
      .state_kernel_i (state_q == KERNEL),
      .irq_pend_i     (irq_pend_q),
      .stall_i        (stall),
      .br_valid_i     (br_valid),
      .br_taken_i     (br_taken),
      .add_out_i      (add_out),
      .jmp_valid_i    (jmp_valid),
      .jmp_target_i   (jmp_target),
      .jr_valid_i     (jr_valid),
      .jr_target_i    (jr_target),
      .eret_valid_i   (eret_valid),
      .id_is_cf_i     (id_is_cf),
      .next_pc_o      (pc_d),
      .flush_if_o     (sel_flush_if),
      .flush_id_o     (sel_flush_id),
      .irq_accept_o   (irq_accept),
      .eret_accept_o  (eret_accept)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (irq_accept)  state_d = KERNEL;
         KERNEL:  if (eret_accept) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Output logic
   always_comb begin
      in_kernel = (state_q == KERNEL);
   end

   // An irq still asserted on the accept edge re-arms the latch for the next entry.
   always_comb begin
      irq_pend_d = irq_pend_q;
      epc_d      = epc_q;
      if (irq_accept) begin
         irq_pend_d = 1'b0;
         epc_d      = pc_q;
      end
      if (irq) begin
         irq_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         epc_q      <= 32'h0000_0000;
         irq_pend_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         irq_pend_q <= irq_pend_d;
      end
   end

   assign pc       = pc_q;
   assign epc      = epc_q;
   assign flush_if = sel_flush_if & ~reset;
   assign flush_id = sel_flush_id & ~reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an ideal adder closing the add_pc/add_imm loop.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_valid, br_taken;
   logic [31:0] br_pc, imm_shift;
   logic [31:0] add_pc, add_imm, add_out;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic        jr_valid;
   logic [31:0] jr_target;
   logic        eret_valid, id_is_cf, irq;
   logic [31:0] pc, epc;
   logic        flush_if, flush_id, in_kernel;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign add_out = add_pc + add_imm;

   pc_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_valid   (br_valid),
      .br_taken   (br_taken),
      .br_pc      (br_pc),
      .imm_shift  (imm_shift),
      .add_pc     (add_pc),
      .add_imm    (add_imm),
      .add_out    (add_out),
      .jmp_valid  (jmp_valid),
      .jmp_target (jmp_target),
      .jr_valid   (jr_valid),
      .jr_target  (jr_target),
      .eret_valid (eret_valid),
      .id_is_cf   (id_is_cf),
      .irq        (irq),
      .pc         (pc),
      .flush_if   (flush_if),
      .flush_id   (flush_id),
      .epc        (epc),
      .in_kernel  (in_kernel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      stall      = 1'b0;
      br_valid   = 1'b0;
      br_taken   = 1'b0;
      br_pc      = 32'h0;
      imm_shift  = 32'h0;
      jmp_valid  = 1'b0;
      jmp_target = 32'h0;
      jr_valid   = 1'b0;
      jr_target  = 32'h0;
      eret_valid = 1'b0;
      id_is_cf   = 1'b0;
      irq        = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;

      // Reset held two cycles; a taken branch during reset must not flush
      br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h100; imm_shift = 32'h0;
      settle();
      check("rst_flush_if", {31'b0, flush_if}, 32'd0);
      check("rst_flush_id", {31'b0, flush_id}, 32'd0);
      tick();
      idle();
      tick();
      check("rst_pc", pc, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_kernel", {31'b0, in_kernel}, 32'd0);
      reset = 1'b0;
      settle();
      check("run_flush_if", {31'b0, flush_if}, 32'd0);
      check("run_flush_id", {31'b0, flush_id}, 32'd0);
      tick(); check("run_pc4", pc, 32'h4);
      tick(); check("run_pc8", pc, 32'h8);
      tick(); check("run_pcC", pc, 32'hC);

      // Taken branch: 0x14 + 0xFFFF_FFF0 = 0x4
      br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h14; imm_shift = 32'hFFFF_FFF0;
      settle();
      check("add_pc", add_pc, 32'h14);
      check("add_imm", add_imm, 32'hFFFF_FFF0);
      check("br_flush_if", {31'b0, flush_if}, 32'd1);
      check("br_flush_id", {31'b0, flush_id}, 32'd1);
      tick();
      check("br_pc", pc, 32'h4);
      idle();
      settle();
      check("br_flush_if_off", {31'b0, flush_if}, 32'd0);
      check("br_flush_id_off", {31'b0, flush_id}, 32'd0);

      // Not-taken branch
      br_valid = 1'b1; br_taken = 1'b0; br_pc = 32'h14; imm_shift = 32'hFFFF_FFF0;
      settle();
      check("nt_flush_if", {31'b0, flush_if}, 32'd0);
      tick();
      check("nt_pc", pc, 32'h8);

      // Branch + jump + stall together: branch wins
      idle();
      br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h30; imm_shift = 32'h10;
      jmp_valid = 1'b1; jmp_target = 32'h100; id_is_cf = 1'b1; stall = 1'b1;
      settle();
      check("col_flush_if", {31'b0, flush_if}, 32'd1);
      check("col_flush_id", {31'b0, flush_id}, 32'd1);
      tick();
      check("col_pc", pc, 32'h40);

      // Stall alone holds pc for three cycles
      idle();
      stall = 1'b1;
      settle();
      check("stall_flush_if", {31'b0, flush_if}, 32'd0);
      tick(); check("stall_pc1", pc, 32'h40);
      tick(); check("stall_pc2", pc, 32'h40);
      tick(); check("stall_pc3", pc, 32'h40);
      stall = 1'b0;
      tick(); check("unstall_pc", pc, 32'h44);

      // Jump from 0x44 to 0x10: IF-only flush
      jmp_valid = 1'b1; jmp_target = 32'h10; id_is_cf = 1'b1;
      settle();
      check("jmp_flush_if", {31'b0, flush_if}, 32'd1);
      check("jmp_flush_id", {31'b0, flush_id}, 32'd0);
      tick(); check("jmp_pc", pc, 32'h10);

      // Register jump to 0x1C, with irq raised alongside (cf defers it)
      idle();
      jr_valid = 1'b1; jr_target = 32'h1C; id_is_cf = 1'b1;
      settle();
      check("jr_flush_if", {31'b0, flush_if}, 32'd1);
      tick(); check("jr_pc", pc, 32'h1C);
      idle();
      irq = 1'b1; id_is_cf = 1'b1;
      tick(); check("irq_pc1C_next", pc, 32'h20);
      irq = 1'b0; id_is_cf = 1'b1;
      settle();
      check("irq_deferred", {31'b0, flush_if}, 32'd0);
      tick();
      check("irq_def_pc", pc, 32'h24);
      check("irq_def_kernel", {31'b0, in_kernel}, 32'd0);
      id_is_cf = 1'b0;
      settle();
      check("irq_acc_flush", {31'b0, flush_if}, 32'd1);
      tick();
      check("irq_pc", pc, 32'h8000_0180);
      check("irq_epc", epc, 32'h24);
      check("irq_kernel", {31'b0, in_kernel}, 32'd1);

      // Second irq while in KERNEL is masked
      irq = 1'b1;
      settle();
      check("mask_flush0", {31'b0, flush_if}, 32'd0);
      tick();
      irq = 1'b0;
      settle();
      check("mask_flush1", {31'b0, flush_if}, 32'd0);
      tick();
      check("mask_pc", pc, 32'h8000_0188);
      check("mask_kernel", {31'b0, in_kernel}, 32'd1);

      // ERET back to epc, pending irq re-enters on the following cycle
      eret_valid = 1'b1; id_is_cf = 1'b1;
      settle();
      check("eret_flush", {31'b0, flush_if}, 32'd1);
      tick();
      check("eret_pc", pc, 32'h24);
      check("eret_run", {31'b0, in_kernel}, 32'd0);
      idle();
      settle();
      check("reirq_flush", {31'b0, flush_if}, 32'd1);
      tick();
      check("reirq_pc", pc, 32'h8000_0180);
      check("reirq_epc", epc, 32'h24);
      check("reirq_kernel", {31'b0, in_kernel}, 32'd1);

      // Reset in KERNEL with irq pending
      irq = 1'b1;
      tick();
      irq = 1'b0;
      reset = 1'b1;
      tick();
      check("mrst_pc", pc, 32'h0);
      check("mrst_epc", epc, 32'h0);
      check("mrst_kernel", {31'b0, in_kernel}, 32'd0);
      reset = 1'b0;
      settle();
      check("mrst_nopend", {31'b0, flush_if}, 32'd0);
      tick();
      check("mrst_pc4", pc, 32'h4);

      // ERET in RUN is ignored
      eret_valid = 1'b1; id_is_cf = 1'b1;
      settle();
      check("eret_run_flush", {31'b0, flush_if}, 32'd0);
      tick();
      check("eret_run_pc", pc, 32'h8);
      idle();

      // Wrap from 0xFFFF_FFFC
      jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC; id_is_cf = 1'b1;
      tick();
      check("wrap_pre", pc, 32'hFFFF_FFFC);
      idle();
      tick();
      check("wrap_pc", pc, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
